// File: rtl/sipo_collector.sv
// Serial-to-parallel frame collector: gathers WIDTH MSB-first bits after a sync
// strobe and presents each completed frame on a valid/ready output register.
module sipo_collector #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sync,
   input  logic             Serial_In,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Parallel_Out,
   output logic             out_valid,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = WIDTH - 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r;
   logic [CW-1:0]    count_r;
   logic [SW-1:0]    shift_r;
   logic [WIDTH-1:0] par_r;
   logic             valid_r;
   logic             overrun_r;

   logic             complete_s;
   logic             load_s;
   logic             drop_s;
   logic [WIDTH-1:0] frame_s;

   // Only WIDTH-1 bits are stored; the last bit comes straight from Serial_In.
   assign frame_s    = {shift_r, Serial_In};
   assign complete_s = (state_r == SHIFT) && (count_r == LAST_CNT);
   assign load_s     = complete_s && (!valid_r || out_ready);
   assign drop_s     = complete_s && valid_r && !out_ready;

   // Frame capture FSM plus output register, valid and sticky overrun.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_r   <= IDLE;
         count_r   <= {CW{1'b0}};
         shift_r   <= {SW{1'b0}};
         par_r     <= {WIDTH{1'b0}};
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (sync) begin
                  shift_r <= SW'(Serial_In);
                  count_r <= CW'(1);
                  state_r <= SHIFT;
               end else begin
                  state_r <= IDLE;
               end
            end
            SHIFT: begin
               // A sync restarts the frame, whether on the last bit or mid-frame.
               if (sync) begin
                  shift_r <= SW'(Serial_In);
                  count_r <= CW'(1);
                  state_r <= SHIFT;
               end else if (complete_s) begin
                  shift_r <= frame_s[SW-1:0];
                  count_r <= FULL_CNT;
                  state_r <= IDLE;
               end else begin
                  shift_r <= frame_s[SW-1:0];
                  count_r <= count_r + CW'(1);
                  state_r <= SHIFT;
               end
            end
            default: begin
               state_r <= IDLE;
               count_r <= {CW{1'b0}};
            end
         endcase

         if (load_s) begin
            par_r   <= frame_s;
            valid_r <= 1'b1;
         end else if (drop_s) begin
            overrun_r <= 1'b1;
         end else if (valid_r && out_ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

   assign Parallel_Out = par_r;
   assign out_valid    = valid_r;
   assign overrun      = overrun_r;
   assign busy         = (state_r == SHIFT);

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector (WIDTH=4): expected frames go into a
// scoreboard queue, a negedge monitor pops them as the DUT presents each frame.
module tb_sipo_collector;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       sync;
   logic       Serial_In;
   logic       out_ready;
   logic [3:0] Parallel_Out;
   logic       out_valid;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];
   logic prev_valid = 1'b0;
   logic prev_ready = 1'b0;

   sipo_collector #(.WIDTH(4)) dut (
      .clk(clk), .clear_n(clear_n), .sync(sync), .Serial_In(Serial_In),
      .out_ready(out_ready), .Parallel_Out(Parallel_Out), .out_valid(out_valid),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic b);
      sync = s;
      Serial_In = b;
      @(posedge clk);
      #1;
      sync = 1'b0;
   endtask

   task automatic frame(input logic [3:0] f);
      for (int i = 3; i >= 0; i--) step(i == 3, f[i]);
   endtask

   // Monitor: a new frame is presented when valid rises or reloads after a handshake.
   always @(negedge clk) begin
      if (!clear_n) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (out_valid && (!prev_valid || prev_ready)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame: got %0h, none expected", Parallel_Out);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (Parallel_Out !== e) begin
                  errors++;
                  $display("FAIL frame_value: got %0h, expected %0h", Parallel_Out, e);
               end
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
      end
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cnt;
      clear_n = 1'b0; sync = 1'b0; Serial_In = 1'b0; out_ready = 1'b0;
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_par", Parallel_Out, 0);
      chk("reset_busy", busy, 0);
      @(posedge clk); @(posedge clk); #3;
      clear_n = 1'b1;

      // Frame 0,1,0,1 with out_ready low; busy counted after each edge
      exp_q.push_back(4'h5);
      busy_cnt = 0;
      step(1'b1, 1'b0); busy_cnt += busy;
      step(1'b0, 1'b1); busy_cnt += busy;
      step(1'b0, 1'b0); busy_cnt += busy;
      step(1'b0, 1'b1); busy_cnt += busy;
      chk("latency_valid", out_valid, 1);
      chk("latency_par", Parallel_Out, 4'h5);
      chk("busy_cycles", busy_cnt, 3);

      // Handshake with nothing in flight
      out_ready = 1'b1;
      step(1'b0, 1'b0);
      out_ready = 1'b0;
      chk("consume_valid", out_valid, 0);
      chk("consume_par_hold", Parallel_Out, 4'h5);

      // Gapless frames 8 then C, consumer always ready
      out_ready = 1'b1;
      exp_q.push_back(4'h8);
      exp_q.push_back(4'hC);
      frame(4'h8);
      chk("b2b_first", Parallel_Out, 4'h8);
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b0);
      chk("b2b_second", Parallel_Out, 4'hC);
      chk("b2b_overrun", overrun, 0);

      // Sync on the completion edge: that bit ends B and starts 9
      exp_q.push_back(4'hB);
      exp_q.push_back(4'h9);
      step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b1, 1'b1);
      chk("shared_first", Parallel_Out, 4'hB);
      chk("shared_busy", busy, 1);
      step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
      chk("shared_second", Parallel_Out, 4'h9);
      chk("shared_idle", busy, 0);
      step(1'b0, 1'b0);
      out_ready = 1'b0;
      chk("shared_drained", out_valid, 0);

      // Overrun: 5 held unconsumed, A dropped
      exp_q.push_back(4'h5);
      frame(4'h5);
      frame(4'hA);
      chk("overrun_par", Parallel_Out, 4'h5);
      chk("overrun_flag", overrun, 1);
      chk("overrun_valid", out_valid, 1);
      out_ready = 1'b1;
      step(1'b0, 1'b0);
      out_ready = 1'b0;
      step(1'b0, 1'b0);
      chk("overrun_sticky", overrun, 1);
      chk("overrun_consumed", out_valid, 0);

      // Abort after two bits, restart with 0,0,1,1
      exp_q.push_back(4'h3);
      step(1'b1, 1'b1); step(1'b0, 1'b1);
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
      chk("abort_no_output", out_valid, 0);
      step(1'b0, 1'b1);
      chk("abort_par", Parallel_Out, 4'h3);
      chk("abort_valid", out_valid, 1);

      // Asynchronous reset during the third bit
      step(1'b1, 1'b1); step(1'b0, 1'b0);
      Serial_In = 1'b0;
      #2;
      clear_n = 1'b0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_par", Parallel_Out, 0);
      chk("async_overrun", overrun, 0);
      chk("async_busy", busy, 0);
      @(posedge clk); #3;
      clear_n = 1'b1;
      step(1'b0, 1'b1);
      chk("post_reset_no_sync", busy, 0);
      exp_q.push_back(4'h9);
      frame(4'h9);
      chk("post_reset_par", Parallel_Out, 4'h9);
      chk("post_reset_valid", out_valid, 1);
      out_ready = 1'b1;
      step(1'b0, 1'b0);
      out_ready = 1'b0;
      step(1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
